// File: rtl/palindrome_generator_if.sv
// Seed/serial/parallel bundle for the palindrome generator.
// The master side is the generator; the slave side supplies seeds and consumes words.
interface palindrome_generator_if #(
   parameter int unsigned WIDTH = 8
);
   localparam int unsigned HALF = WIDTH / 2;

   logic            seed_valid;
   logic [HALF-1:0] seed;
   logic            seed_ready;
   logic            ser_out;
   logic            ser_valid;
   logic            ser_last;
   logic [WIDTH-1:0] data_out;
   logic            data_valid;
   logic            data_ready;

   modport master (
      input  seed_valid, seed, data_ready,
      output seed_ready, ser_out, ser_valid, ser_last, data_out, data_valid
   );

   modport slave (
      output seed_valid, seed, data_ready,
      input  seed_ready, ser_out, ser_valid, ser_last, data_out, data_valid
   );
endinterface

// File: rtl/palindrome_generator.sv
// Builds {seed, bit_reverse(seed)}, shifts it out MSB first, then holds it on a
// parallel port until the consumer acknowledges.
module palindrome_generator #(
   parameter int unsigned WIDTH = 8
) (
   input logic                  clk,
   input logic                  rst,
   palindrome_generator_if.master bus
);
   localparam int unsigned HALF = WIDTH / 2;
   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] word;
   logic [WIDTH-1:0] shift_rot;

   always_comb begin
      word = '0;
      word[WIDTH-1:HALF] = bus.seed;
      for (int i = 0; i < int'(HALF); i++) begin
         word[i] = bus.seed[HALF-1-i];
      end
   end

   // Rotating rather than plain shifting leaves the full word in the register
   // after WIDTH steps, so it can be copied to the parallel port.
   assign shift_rot = {shift_q[WIDTH-2:0], shift_q[WIDTH-1]};

   always_comb begin
      state_d        = state_q;
      shift_d        = shift_q;
      cnt_d          = cnt_q;
      data_d         = data_q;
      bus.seed_ready = 1'b0;
      bus.ser_valid  = 1'b0;
      bus.ser_out    = 1'b0;
      bus.ser_last   = 1'b0;
      bus.data_valid = 1'b0;
      unique case (state_q)
         StIdle: begin
            bus.seed_ready = 1'b1;
            if (bus.seed_valid) begin
               shift_d = word;
               cnt_d   = '0;
               state_d = StShift;
            end
         end
         StShift: begin
            bus.ser_valid = 1'b1;
            bus.ser_out   = shift_q[WIDTH-1];
            bus.ser_last  = (cnt_q == LastCnt);
            shift_d       = shift_rot;
            if (cnt_q == LastCnt) begin
               data_d  = shift_rot;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDone: begin
            bus.data_valid = 1'b1;
            if (bus.data_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.data_out = data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         shift_q <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end
endmodule

// File: tb/tb_palindrome_generator.sv
// Directed bench for palindrome_generator at WIDTH=8 and WIDTH=16.
module tb_palindrome_generator;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   palindrome_generator_if #(.WIDTH(8))  bus8 ();
   palindrome_generator_if #(.WIDTH(16)) bus16 ();

   palindrome_generator #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
   palindrome_generator #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0] seed;
      int         hold;
      logic [7:0] word;
      bit         noise;
   } vec_t;

   vec_t vecs[8];

   // Accept one seed, check every serial bit, then the DONE hold and handshake.
   task automatic run_word(input logic [3:0] s, input int hold, input logic [7:0] w,
                           input bit noise);
      @(negedge clk);
      check("idle seed_ready", 32'(bus8.seed_ready), 1);
      check("idle ser_valid", 32'(bus8.ser_valid), 0);
      bus8.seed       = s;
      bus8.seed_valid = 1'b1;
      bus8.data_ready = 1'b0;
      @(negedge clk);
      bus8.seed_valid = noise;
      bus8.seed       = noise ? 4'b0001 : ~s;
      for (int i = 0; i < 8; i++) begin
         check("ser_valid", 32'(bus8.ser_valid), 1);
         check("ser_out", 32'(bus8.ser_out), 32'(w[7-i]));
         check("ser_last", 32'(bus8.ser_last), 32'(i == 7));
         check("shift seed_ready", 32'(bus8.seed_ready), 0);
         check("shift data_valid", 32'(bus8.data_valid), 0);
         if (i == 7) begin
            bus8.data_ready = (hold == 0);
            bus8.seed_valid = 1'b0;
         end
         @(negedge clk);
      end
      for (int k = 0; k <= hold; k++) begin
         bus8.data_ready = (k == hold);
         check("done data_valid", 32'(bus8.data_valid), 1);
         check("done data_out", 32'(bus8.data_out), 32'(w));
         check("done seed_ready", 32'(bus8.seed_ready), 0);
         check("done ser_valid", 32'(bus8.ser_valid), 0);
         check("done ser_out", 32'(bus8.ser_out), 0);
         @(negedge clk);
      end
      bus8.data_ready = 1'b0;
      check("post data_valid", 32'(bus8.data_valid), 0);
      check("post seed_ready", 32'(bus8.seed_ready), 1);
      check("post data_out kept", 32'(bus8.data_out), 32'(w));
   endtask

   initial begin
      logic [15:0] exp16;
      logic [7:0]  words[2];
      int          rise[2];
      int          nrise;
      int          nwords;
      int          cyc;
      logic        prev;

      vecs[0] = '{4'b1100, 0, 8'b11000011, 1'b0};
      vecs[1] = '{4'b1011, 3, 8'b10111101, 1'b0};
      vecs[2] = '{4'b1010, 1, 8'b10100101, 1'b1};
      vecs[3] = '{4'b0001, 2, 8'b00011000, 1'b0};
      vecs[4] = '{4'b1111, 0, 8'b11111111, 1'b0};
      vecs[5] = '{4'b0000, 0, 8'b00000000, 1'b1};
      vecs[6] = '{4'b0110, 0, 8'b01100110, 1'b0};
      vecs[7] = '{4'b1001, 2, 8'b10011001, 1'b0};

      bus8.seed_valid  = 1'b0;
      bus8.seed        = '0;
      bus8.data_ready  = 1'b0;
      bus16.seed_valid = 1'b0;
      bus16.seed       = '0;
      bus16.data_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst seed_ready", 32'(bus8.seed_ready), 1);
      check("rst ser_valid", 32'(bus8.ser_valid), 0);
      check("rst ser_out", 32'(bus8.ser_out), 0);
      check("rst ser_last", 32'(bus8.ser_last), 0);
      check("rst data_out", 32'(bus8.data_out), 0);
      check("rst data_valid", 32'(bus8.data_valid), 0);
      check("rst16 data_out", 32'(bus16.data_out), 0);
      rst = 1'b0;

      for (int v = 0; v < 8; v++) begin
         run_word(vecs[v].seed, vecs[v].hold, vecs[v].word, vecs[v].noise);
      end

      // Reset in the middle of a word.
      @(negedge clk);
      bus8.seed       = 4'b1110;
      bus8.seed_valid = 1'b1;
      @(negedge clk);
      bus8.seed_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("pre-rst ser_valid", 32'(bus8.ser_valid), 1);
         check("pre-rst ser_out", 32'(bus8.ser_out), 1);
         if (i < 2) @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst ser_valid", 32'(bus8.ser_valid), 0);
      check("midrst ser_out", 32'(bus8.ser_out), 0);
      check("midrst data_valid", 32'(bus8.data_valid), 0);
      check("midrst data_out", 32'(bus8.data_out), 0);
      check("midrst seed_ready", 32'(bus8.seed_ready), 1);
      @(negedge clk);
      check("midrst stays idle", 32'(bus8.ser_valid), 0);
      run_word(4'b0110, 0, 8'b01100110, 1'b0);

      // Back-to-back seeds with seed_valid held high.
      @(negedge clk);
      bus8.seed       = 4'b1000;
      bus8.seed_valid = 1'b1;
      bus8.data_ready = 1'b1;
      prev   = 1'b0;
      nrise  = 0;
      nwords = 0;
      cyc    = 0;
      rise[0] = 0;
      rise[1] = 0;
      words[0] = '0;
      words[1] = '0;
      while (cyc < 60 && nwords < 2) begin
         @(negedge clk);
         cyc++;
         if (bus8.ser_valid && !prev && nrise < 2) begin
            rise[nrise] = cyc;
            nrise++;
            bus8.seed = 4'b0100;
         end
         if (bus8.data_valid) begin
            words[nwords] = bus8.data_out;
            nwords++;
         end
         prev = bus8.ser_valid;
      end
      bus8.seed_valid = 1'b0;
      check("b2b word count", 32'(nwords), 2);
      check("b2b word0", 32'(words[0]), 32'(8'b10000001));
      check("b2b word1", 32'(words[1]), 32'(8'b01000010));
      check("b2b burst spacing", 32'(rise[1] - rise[0]), 10);
      @(negedge clk);
      bus8.data_ready = 1'b0;
      check("b2b back to idle", 32'(bus8.seed_ready), 1);

      // WIDTH=16 instance.
      exp16 = 16'h1248;
      @(negedge clk);
      bus16.seed       = 8'h12;
      bus16.seed_valid = 1'b1;
      bus16.data_ready = 1'b1;
      @(negedge clk);
      bus16.seed_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         check("w16 ser_valid", 32'(bus16.ser_valid), 1);
         check("w16 ser_out", 32'(bus16.ser_out), 32'(exp16[15-i]));
         check("w16 ser_last", 32'(bus16.ser_last), 32'(i == 15));
         @(negedge clk);
      end
      check("w16 data_valid", 32'(bus16.data_valid), 1);
      check("w16 data_out", 32'(bus16.data_out), 32'h1248);
      @(negedge clk);
      check("w16 data_valid cleared", 32'(bus16.data_valid), 0);
      check("w16 seed_ready", 32'(bus16.seed_ready), 1);
      check("w16 data_out kept", 32'(bus16.data_out), 32'h1248);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
